// File: rtl/spi_seq_ctrl.sv
// spi_seq_ctrl
//   Issues SPI transactions to NUM_CH external engines using a start/done
//   handshake. It optionally compares the response against a masked
//   expected value and retries on a mismatch. Each transaction has a
//   timeout, and there is a fixed idle gap between transactions.
//
// Ports
//   i_sys_clk_pin, i_rst      clock (rising edge), async active-high reset
//   i_cmd_*, o_cmd_ready      command channel (valid/ready)
//   o_spi_start               one-hot, one-clock start pulse to engine ch
//   o_spi_in_count/_bytes     tx byte count and payload, held until next accept
//   o_spi_out_count           rx byte count to the engine
//   i_spi_out_bytes           rx data from all engines, slice ch*8*MAX_RX_BYTES
//   i_spi_done                one-clock done pulse per engine
//   o_rsp_*                   one-clock response strobe; fields held until next strobe
//   o_busy, o_state_dbg       status and debug
//
// state  | meaning
// IDLE   | ready for a command
// LAUNCH | start pulse high for the latched channel
// WAIT   | waiting for done from that channel, timeout running
// CHECK  | compare captured rx data, decide ok / retry / mismatch
// GAP    | idle spacing before relaunch or return to IDLE
module spi_seq_ctrl #(
  parameter int NUM_CH       = 3,
  parameter int MAX_TX_BYTES = 4,
  parameter int MAX_RX_BYTES = 4,
  parameter int GAP_CYCLES   = 40000000,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int MAX_RETRY    = 7,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TXW = $clog2(MAX_TX_BYTES + 1),
  localparam int RXW = $clog2(MAX_RX_BYTES + 1),
  localparam int TXB = 8 * MAX_TX_BYTES,
  localparam int RXB = 8 * MAX_RX_BYTES
) (
  input  logic                  i_sys_clk_pin,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [CHW-1:0]        i_cmd_ch,
  input  logic [TXW-1:0]        i_cmd_tx_len,
  input  logic [RXW-1:0]        i_cmd_rx_len,
  input  logic [TXB-1:0]        i_cmd_tx_data,
  input  logic                  i_cmd_chk_en,
  input  logic [RXB-1:0]        i_cmd_expect,
  input  logic [RXB-1:0]        i_cmd_mask,
  output logic [NUM_CH-1:0]     o_spi_start,
  output logic [TXW-1:0]        o_spi_in_count,
  output logic [RXW-1:0]        o_spi_out_count,
  output logic [TXB-1:0]        o_spi_in_bytes,
  input  logic [NUM_CH*RXB-1:0] i_spi_out_bytes,
  input  logic [NUM_CH-1:0]     i_spi_done,
  output logic                  o_rsp_valid,
  output logic [CHW-1:0]        o_rsp_ch,
  output logic [RXB-1:0]        o_rsp_data,
  output logic [1:0]            o_rsp_status,
  output logic                  o_busy,
  output logic [2:0]            o_state_dbg
);

  localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [RTW-1:0] RT_MAX   = RTW'(MAX_RETRY);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_MISMATCH = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;
  localparam logic [1:0] ST_BAD_CH   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_busy;
  logic [CHW-1:0]    r_ch;
  logic [TXW-1:0]    r_tx_len;
  logic [RXW-1:0]    r_rx_len;
  logic [TXB-1:0]    r_tx_data;
  logic              r_chk_en;
  logic [RXB-1:0]    r_expect;
  logic [RXB-1:0]    r_mask;
  logic [NUM_CH-1:0] r_spi_start;
  logic [TOW-1:0]    r_to_cnt;
  logic [GW-1:0]     r_gap_cnt;
  logic [RTW-1:0]    r_retry;
  logic              r_relaunch;
  logic [RXB-1:0]    r_rx_cap;
  logic              r_rsp_valid;
  logic [CHW-1:0]    r_rsp_ch;
  logic [RXB-1:0]    r_rsp_data;
  logic [1:0]        r_rsp_status;

  logic [RXB-1:0]    w_len_mask;
  logic [RXB-1:0]    w_rx_slice;
  logic              w_done;
  logic              w_timeout;
  logic              w_match;
  logic              w_ch_ok;
  logic              w_accept;

  function automatic logic [NUM_CH-1:0] f_onehot(input logic [CHW-1:0] ch);
    f_onehot     = '0;
    f_onehot[ch] = 1'b1;
  endfunction

  // Byte lanes at or above rx_len are excluded from both capture and compare,
  // so rx_len = 0 always matches.
  always_comb begin
    w_len_mask = '0;
    for (int i = 0; i < MAX_RX_BYTES; i++) begin
      if (int'(r_rx_len) > i) w_len_mask[8*i +: 8] = 8'hFF;
    end
  end

  assign w_rx_slice = i_spi_out_bytes[r_ch*RXB +: RXB];
  assign w_done     = i_spi_done[r_ch];
  assign w_timeout  = (r_to_cnt >= TO_LAST);
  assign w_match    = (((r_rx_cap ^ r_expect) & r_mask & w_len_mask) == '0);
  assign w_ch_ok    = (int'(i_cmd_ch) < NUM_CH);
  assign w_accept   = i_cmd_valid && r_cmd_ready;

  always_ff @(posedge i_sys_clk_pin or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_ch         <= '0;
      r_tx_len     <= '0;
      r_rx_len     <= '0;
      r_tx_data    <= '0;
      r_chk_en     <= 1'b0;
      r_expect     <= '0;
      r_mask       <= '0;
      r_spi_start  <= '0;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_retry      <= '0;
      r_relaunch   <= 1'b0;
      r_rx_cap     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_ch     <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= 2'b00;
    end else begin
      r_spi_start <= '0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_ch      <= i_cmd_ch;
            r_tx_len  <= i_cmd_tx_len;
            r_rx_len  <= i_cmd_rx_len;
            r_tx_data <= i_cmd_tx_data;
            r_chk_en  <= i_cmd_chk_en;
            r_expect  <= i_cmd_expect;
            r_mask    <= i_cmd_mask;
            if (!w_ch_ok) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_ch     <= i_cmd_ch;
              r_rsp_data   <= '0;
              r_rsp_status <= ST_BAD_CH;
            end else begin
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_spi_start <= f_onehot(i_cmd_ch);
              r_to_cnt    <= '0;
              r_retry     <= '0;
              r_relaunch  <= 1'b0;
              r_state     <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          // The timeout counts clocks since the start pulse, LAUNCH included.
          r_to_cnt <= r_to_cnt + TOW'(1);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done) begin
            r_rx_cap <= w_rx_slice & w_len_mask;
            r_state  <= S_CHECK;
          end else if (w_timeout) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_ch     <= r_ch;
            r_rsp_data   <= '0;
            r_rsp_status <= ST_TIMEOUT;
            r_relaunch   <= 1'b0;
            r_gap_cnt    <= GAP_LOAD;
            r_state      <= S_GAP;
          end else begin
            r_to_cnt <= r_to_cnt + TOW'(1);
          end
        end
        S_CHECK: begin
          r_gap_cnt <= GAP_LOAD;
          r_state   <= S_GAP;
          if (!r_chk_en || w_match) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_ch     <= r_ch;
            r_rsp_data   <= r_rx_cap;
            r_rsp_status <= ST_OK;
            r_relaunch   <= 1'b0;
          end else if (r_retry < RT_MAX) begin
            r_retry    <= r_retry + RTW'(1);
            r_relaunch <= 1'b1;
          end else begin
            r_rsp_valid  <= 1'b1;
            r_rsp_ch     <= r_ch;
            r_rsp_data   <= r_rx_cap;
            r_rsp_status <= ST_MISMATCH;
            r_relaunch   <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            if (r_relaunch) begin
              r_relaunch  <= 1'b0;
              r_spi_start <= f_onehot(r_ch);
              r_to_cnt    <= '0;
              r_state     <= S_LAUNCH;
            end else begin
              r_retry     <= '0;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready     = r_cmd_ready;
  assign o_spi_start     = r_spi_start;
  assign o_spi_in_count  = r_tx_len;
  assign o_spi_out_count = r_rx_len;
  assign o_spi_in_bytes  = r_tx_data;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_ch        = r_rsp_ch;
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_status    = r_rsp_status;
  assign o_busy          = r_busy;
  assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// Directed bench for spi_seq_ctrl with small timing parameters
// (GAP_CYCLES=5, TIMEOUT_CYC=16, MAX_RETRY=2, NUM_CH=3).
module tb_spi_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_ch = '0;
  logic [2:0]  cmd_tx_len = '0;
  logic [2:0]  cmd_rx_len = '0;
  logic [31:0] cmd_tx_data = '0;
  logic        cmd_chk_en = 1'b0;
  logic [31:0] cmd_expect = '0;
  logic [31:0] cmd_mask = '0;
  logic [2:0]  spi_start;
  logic [2:0]  spi_in_count;
  logic [2:0]  spi_out_count;
  logic [31:0] spi_in_bytes;
  logic [95:0] spi_out_bytes = '0;
  logic [2:0]  spi_done = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_ch;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  int starts_mark = 0;
  logic prev_rsp = 1'b0;

  spi_seq_ctrl #(
    .NUM_CH(3), .MAX_TX_BYTES(4), .MAX_RX_BYTES(4),
    .GAP_CYCLES(5), .TIMEOUT_CYC(16), .MAX_RETRY(2)
  ) dut (
    .i_sys_clk_pin   (clk),
    .i_rst           (rst),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_ch        (cmd_ch),
    .i_cmd_tx_len    (cmd_tx_len),
    .i_cmd_rx_len    (cmd_rx_len),
    .i_cmd_tx_data   (cmd_tx_data),
    .i_cmd_chk_en    (cmd_chk_en),
    .i_cmd_expect    (cmd_expect),
    .i_cmd_mask      (cmd_mask),
    .o_spi_start     (spi_start),
    .o_spi_in_count  (spi_in_count),
    .o_spi_out_count (spi_out_count),
    .o_spi_in_bytes  (spi_in_bytes),
    .i_spi_out_bytes (spi_out_bytes),
    .i_spi_done      (spi_done),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_ch        (rsp_ch),
    .o_rsp_data      (rsp_data),
    .o_rsp_status    (rsp_status),
    .o_busy          (busy),
    .o_state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers a command and returns 1 time unit after the accepting edge.
  task automatic send_cmd(input logic [1:0] ch, input logic [2:0] txl, input logic [2:0] rxl,
                          input logic [31:0] txd, input logic chk_en,
                          input logic [31:0] expv, input logic [31:0] msk);
    int n;
    cmd_ch      = ch;
    cmd_tx_len  = txl;
    cmd_rx_len  = rxl;
    cmd_tx_data = txd;
    cmd_chk_en  = chk_en;
    cmd_expect  = expv;
    cmd_mask    = msk;
    cmd_valid   = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  // Start pulse counting and the never-two-clocks rsp_valid rule.
  always @(negedge clk) begin
    if (spi_start != 3'b000) n_starts++;
    if (rsp_valid) chk("rsp_valid_single_clock", 64'(prev_rsp), 64'd0);
    prev_rsp <= rsp_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_state", 64'(state_dbg), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_start", 64'(spi_start), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // 1: ch1, tx {0x4E,0x01}, rx 0, done 10 clocks after start
    spi_out_bytes[32 +: 32] = 32'hDEADBEEF;
    starts_mark = n_starts;
    send_cmd(2'd1, 3'd2, 3'd0, 32'h0000_014E, 1'b0, 32'h0, 32'h0);
    chk("t1_start", 64'(spi_start), 64'b010);
    chk("t1_in_count", 64'(spi_in_count), 64'd2);
    chk("t1_in_bytes", 64'(spi_in_bytes), 64'h014E);
    chk("t1_out_count", 64'(spi_out_count), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_state_launch", 64'(state_dbg), 64'd1);
    tick(1);
    chk("t1_start_one_clock", 64'(spi_start), 64'd0);
    chk("t1_state_wait", 64'(state_dbg), 64'd2);
    tick(9);
    spi_done = 3'b010;
    tick(1);
    spi_done = 3'b000;
    chk("t1_state_check", 64'(state_dbg), 64'd3);
    chk("t1_rsp_not_yet", 64'(rsp_valid), 64'd0);
    tick(1);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_status", 64'(rsp_status), 64'd0);
    chk("t1_rsp_ch", 64'(rsp_ch), 64'd1);
    chk("t1_rsp_data_zero_len", 64'(rsp_data), 64'd0);
    tick(1);
    chk("t1_rsp_drop", 64'(rsp_valid), 64'd0);
    chk("t1_rsp_ch_held", 64'(rsp_ch), 64'd1);
    tick(3);
    chk("t1_state_gap", 64'(state_dbg), 64'd4);
    tick(1);
    chk("t1_state_idle", 64'(state_dbg), 64'd0);
    chk("t1_ready_again", 64'(cmd_ready), 64'd1);
    chk("t1_start_count", 64'(n_starts - starts_mark), 64'd1);

    // 2: compare pass, stray done on ch0 while waiting on ch2
    starts_mark = n_starts;
    send_cmd(2'd2, 3'd1, 3'd2, 32'h0000_00AA, 1'b1, 32'h0000_8103, 32'h0000_FFFF);
    chk("t2_start", 64'(spi_start), 64'b100);
    tick(1);
    spi_out_bytes[0 +: 32] = 32'h1111_1111;
    spi_done = 3'b001;
    tick(1);
    spi_done = 3'b000;
    chk("t2_stray_done_ignored", 64'(state_dbg), 64'd2);
    spi_out_bytes[64 +: 32] = 32'hFFFF_8103;
    spi_done = 3'b100;
    tick(1);
    spi_done = 3'b000;
    chk("t2_state_check", 64'(state_dbg), 64'd3);
    tick(1);
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_rsp_status", 64'(rsp_status), 64'd0);
    chk("t2_rsp_ch", 64'(rsp_ch), 64'd2);
    chk("t2_rsp_data", 64'(rsp_data), 64'h0000_8103);
    tick(5);
    chk("t2_idle", 64'(state_dbg), 64'd0);
    chk("t2_start_count", 64'(n_starts - starts_mark), 64'd1);

    // 3: persistent mismatch, retries exhausted
    spi_out_bytes[0 +: 32] = 32'h0;
    starts_mark = n_starts;
    send_cmd(2'd0, 3'd0, 3'd2, 32'h0, 1'b1, 32'h0000_1234, 32'h0000_FFFF);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        tick(4);
        chk("t3_no_early_start", 64'(spi_start), 64'd0);
        tick(1);
      end
      chk("t3_start", 64'(spi_start), 64'b001);
      tick(1);
      spi_done = 3'b001;
      tick(1);
      spi_done = 3'b000;
      tick(1);
      chk("t3_rsp_valid", 64'(rsp_valid), 64'(k == 2));
    end
    chk("t3_rsp_status", 64'(rsp_status), 64'd1);
    chk("t3_rsp_data", 64'(rsp_data), 64'd0);
    chk("t3_start_count", 64'(n_starts - starts_mark), 64'd3);
    tick(5);
    chk("t3_idle", 64'(state_dbg), 64'd0);

    // 4: timeout, no done
    send_cmd(2'd1, 3'd1, 3'd1, 32'h55, 1'b0, 32'h0, 32'h0);
    chk("t4_start", 64'(spi_start), 64'b010);
    tick(15);
    chk("t4_no_rsp_yet", 64'(rsp_valid), 64'd0);
    chk("t4_still_wait", 64'(state_dbg), 64'd2);
    tick(1);
    chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t4_rsp_status", 64'(rsp_status), 64'd2);
    chk("t4_state_gap", 64'(state_dbg), 64'd4);
    tick(4);
    chk("t4_gap_held", 64'(state_dbg), 64'd4);
    tick(1);
    chk("t4_idle", 64'(state_dbg), 64'd0);

    // 5: bad channel
    starts_mark = n_starts;
    send_cmd(2'd3, 3'd0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t5_rsp_status", 64'(rsp_status), 64'd3);
    chk("t5_rsp_ch", 64'(rsp_ch), 64'd3);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_state", 64'(state_dbg), 64'd0);
    tick(1);
    chk("t5_busy_after", 64'(busy), 64'd0);
    chk("t5_no_start", 64'(n_starts - starts_mark), 64'd0);

    // 6: reset while in WAIT
    starts_mark = n_starts;
    send_cmd(2'd0, 3'd3, 3'd1, 32'h00AB_CDEF, 1'b0, 32'h0, 32'h0);
    tick(3);
    chk("t6_in_wait", 64'(state_dbg), 64'd2);
    rst = 1'b1;
    #2;
    chk("t6_rst_state", 64'(state_dbg), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(cmd_ready), 64'd0);
    chk("t6_rst_in_count", 64'(spi_in_count), 64'd0);
    chk("t6_rst_in_bytes", 64'(spi_in_bytes), 64'd0);
    chk("t6_rst_rsp_status", 64'(rsp_status), 64'd0);
    chk("t6_rst_rsp_ch", 64'(rsp_ch), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("t6_ready_after_rst", 64'(cmd_ready), 64'd1);
    chk("t6_no_rsp", 64'(rsp_valid), 64'd0);
    chk("t6_start_count", 64'(n_starts - starts_mark), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
